// File: rtl/led_pkg.sv
// Shared types and helpers for the LED pattern driver.
package led_pkg;

    typedef enum logic [1:0] {
        LED_STATIC = 2'b00,
        LED_BLINK  = 2'b01,
        LED_SCAN   = 2'b10,
        LED_RSVD   = 2'b11
    } led_mode_e;

    // Widest bank the helper can build; callers size-cast the result down.
    localparam int LED_MAX_W = 64;
    localparam int IDX_MAX_W = 6;

    // One lit LED at idx, polarity applied (pol=1: lit is 0, dark is 1).
    function automatic logic [LED_MAX_W-1:0] onehot_dark(input logic [IDX_MAX_W-1:0] idx,
                                                        input logic pol);
        logic [LED_MAX_W-1:0] hot;
        hot = {{(LED_MAX_W-1){1'b0}}, 1'b1} << idx;
        return pol ? ~hot : hot;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every DIV cycles while run is high.
module tick_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // A clear or an idle cycle suppresses the tick so a restart never steps immediately.
    assign tick = run && !clr && (cnt == LAST);

    // Counter wraps at DIV-1 and parks at zero whenever cleared or not running.
    always_ff @(posedge clk) begin
        if (rst || clr || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_pattern_driver.sv
// Registered LED bank driver: static one-hot, blinking one-hot or scanning running light.
module led_pattern_driver
    import led_pkg::*;
#(
    parameter int                SEL_W      = 3,
    parameter int                EN_W       = 3,
    parameter logic [EN_W-1:0]   EN_MATCH   = EN_W'(4),
    parameter int                TICK_DIV   = 4,
    parameter bit                ACTIVE_LOW = 1'b1,
    localparam int               LED_N      = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [EN_W-1:0]  enable,
    input  logic [SEL_W-1:0] switch,
    input  logic [1:0]       mode,
    output logic [LED_N-1:0] led
);
    localparam logic [LED_N-1:0] DARK = {LED_N{ACTIVE_LOW}};

    led_mode_e        cur_mode;
    logic             armed;
    logic             restart;
    logic             run;
    logic             tick;

    led_mode_e        mode_p1;
    logic             armed_p1;
    logic             phase_on_p1;
    logic [SEL_W-1:0] pos_p1;

    logic             phase_on_nxt;
    logic [SEL_W-1:0] pos_nxt;
    logic [LED_N-1:0] led_nxt;

    assign cur_mode = led_mode_e'(mode);
    assign armed    = (enable == EN_MATCH) && (cur_mode != LED_RSVD);
    // Disarm, re-arm and any mode change all restart the pattern from its initial state.
    assign restart  = !armed || !armed_p1 || (cur_mode != mode_p1);
    assign run      = armed && (cur_mode != LED_STATIC);

    tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .run  (run),
        .tick (tick)
    );

    // Next phase/position; the output is built from these so the first cycle shows the initial pattern.
    always_comb begin
        phase_on_nxt = 1'b1;
        pos_nxt      = switch;
        if (!restart) begin
            phase_on_nxt = tick ? !phase_on_p1 : phase_on_p1;
            pos_nxt      = pos_p1;
            if (tick && (cur_mode == LED_SCAN)) begin
                pos_nxt = switch[0] ? (pos_p1 - SEL_W'(1)) : (pos_p1 + SEL_W'(1));
            end
        end
    end

    // Pattern selection; anything not armed is a fully dark bank.
    always_comb begin
        led_nxt = DARK;
        if (armed) begin
            case (cur_mode)
                LED_STATIC: led_nxt = LED_N'(onehot_dark(IDX_MAX_W'(switch), ACTIVE_LOW));
                LED_BLINK:  led_nxt = phase_on_nxt ?
                                      LED_N'(onehot_dark(IDX_MAX_W'(switch), ACTIVE_LOW)) : DARK;
                LED_SCAN:   led_nxt = LED_N'(onehot_dark(IDX_MAX_W'(pos_nxt), ACTIVE_LOW));
                default:    led_nxt = DARK;
            endcase
        end
    end

    // State and output registers; reset leaves the bank dark with phase ON and position 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            led         <= DARK;
            armed_p1    <= 1'b0;
            mode_p1     <= LED_STATIC;
            phase_on_p1 <= 1'b1;
            pos_p1      <= '0;
        end else begin
            led         <= led_nxt;
            armed_p1    <= armed;
            mode_p1     <= cur_mode;
            phase_on_p1 <= phase_on_nxt;
            pos_p1      <= pos_nxt;
        end
    end

endmodule
